// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, mode enumeration and mode helpers.
// Both the master and a future slave import this package.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_e;

  // Mode number is {CPOL, CPHA}.
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_e;

  function automatic spi_mode_e spi_mode(input logic cpol, input logic cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

  // Modes 0 and 2 sample on the leading SCK edge, modes 1 and 3 on the trailing edge.
  function automatic logic spi_samples_on_lead(input spi_mode_e mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE2);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK half-period generator. While enabled, SCK toggles every CLK_DIV clk cycles.
// lead_edge/trail_edge are high in the clk cycle whose closing rising edge
// toggles SCK, so the master can act on the same clk edge as the SCK change.
module spi_clk_gen #(
  parameter int CLK_DIV = 2,
  parameter int CPOL    = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic lead_edge,
  output logic trail_edge,
  output logic sck
);

  localparam int            CW       = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST     = CW'(CLK_DIV - 1);
  localparam logic          IDLE_LVL = 1'(CPOL);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tick;

  // Half-period counter wraps at CLK_DIV-1; SCK toggles on the wrap, parks at CPOL when disabled.
  always_comb begin
    tick  = enable && (cnt_q == LAST);
    cnt_d = '0;
    sck_d = IDLE_LVL;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      sck_d = tick ? ~sck_q : sck_q;
    end
  end

  // Counter and SCK registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= IDLE_LVL;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign lead_edge  = tick && (sck_q == IDLE_LVL);
  assign trail_edge = tick && (sck_q != IDLE_LVL);
  assign sck        = sck_q;

endmodule

// File: rtl/spi_master.sv
// SPI master: LSB-first frames of DATA_LENGTH bits in any CPOL/CPHA mode.
// SS is held low for (2*DATA_LENGTH+2)*CLK_DIV cycles: one half-period of lead-in,
// 2*DATA_LENGTH SCK half-periods, one half-period of tail.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int CLK_DIV     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] data_in,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_LENGTH-1:0] data_out,
  output logic                   SS,
  output logic                   SCK,
  output logic                   MOSI,
  input  logic                   MISO
);

  localparam int               N         = DATA_LENGTH;
  localparam int               HW        = $clog2(CLK_DIV + 1);
  localparam int               EW        = $clog2(2 * N);
  localparam logic [HW-1:0]    HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [EW-1:0]    EDGE_LAST = EW'(2 * N - 1);
  localparam spi_mode_e        MODE      = spi_mode(1'(CPOL), 1'(CPHA));
  localparam logic             SAMP_LEAD = spi_samples_on_lead(MODE);
  localparam logic             SHIFT_LEAD = 1'(CPHA);

  spi_state_e    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [EW-1:0] ecnt_q, ecnt_d;
  logic [N-1:0]  tx_q, tx_d;
  logic [N-1:0]  rx_q, rx_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          mosi_q, mosi_d;
  logic          done_q, done_d;
  logic          ss_q, ss_d;
  logic          miso_meta_q, miso_sync_q;
  logic [1:0]    samp_q;

  logic lead_edge, trail_edge, any_edge, final_edge, sample_edge, half_end;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (state_q == ST_XFER),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .sck        (SCK)
  );

  // Next-state logic: FSM sequencing, TX shifting, RX capture and frame completion.
  always_comb begin
    state_d = state_q;
    hcnt_d  = '0;
    ecnt_d  = ecnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    half_end    = (hcnt_q == HALF_LAST);
    any_edge    = lead_edge || trail_edge;
    final_edge  = any_edge && (ecnt_q == EDGE_LAST);
    sample_edge = SAMP_LEAD ? lead_edge : trail_edge;

    // A sample strobe delayed by the two synchronizer stages picks up the MISO
    // level that was present at the SCK sample edge itself. The final sample
    // lands no later than the done edge except for CPHA=1 with CLK_DIV=1.
    if (samp_q[1]) begin
      rx_d        = rx_q >> 1;
      rx_d[N-1]   = miso_sync_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LEAD;
          ecnt_d  = '0;
          if (SHIFT_LEAD) begin
            tx_d   = data_in;
            mosi_d = 1'b0;
          end else begin
            tx_d   = data_in >> 1;
            mosi_d = data_in[0];
          end
        end
      end
      ST_LEAD: begin
        hcnt_d = half_end ? '0 : hcnt_q + 1'b1;
        if (half_end) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (any_edge) ecnt_d = final_edge ? '0 : ecnt_q + 1'b1;
        if ((SHIFT_LEAD && lead_edge) || (!SHIFT_LEAD && trail_edge && !final_edge)) begin
          mosi_d = tx_q[0];
          tx_d   = tx_q >> 1;
        end
        if (final_edge) state_d = ST_TRAIL;
      end
      ST_TRAIL: begin
        hcnt_d = half_end ? '0 : hcnt_q + 1'b1;
        if (half_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          dout_d  = rx_d;
          mosi_d  = 1'b0;
          tx_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ss_d = (state_d == ST_IDLE);
  end

  // Frame state registers; reset parks the interface idle even mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      ecnt_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      ss_q    <= 1'b1;
      samp_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      ecnt_q  <= ecnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      ss_q    <= ss_d;
      samp_q  <= {samp_q[0], sample_edge};
    end
  end

  // Two-flop synchronizer for the asynchronous MISO input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      miso_meta_q <= MISO;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign SS       = ss_q;
  assign busy     = ~ss_q;
  assign done     = done_q;
  assign data_out = dout_q;
  assign MOSI     = mosi_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_LENGTH, default 8, sets the frame width in bits.
REQ-002 Parameter CPOL, default 0, sets the SCK idle level.
REQ-003 Parameter CPHA, default 0: 0 = sample on the leading edge, shift on the trailing edge; 1 = shift on the leading edge, sample on the trailing edge.
REQ-004 Parameter CLK_DIV, default 2, sets the SCK half-period in clk cycles; legal range is CLK_DIV >= 1.
REQ-005 clk  in  1  single system clock; all logic SHALL be rising-edge clk.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle transfer request.
REQ-008 data_in  in  DATA_LENGTH  word to transmit; captured when start is accepted.
REQ-009 busy  out  1  high from the accept cycle until the cycle the done pulse is issued.
REQ-010 done  out  1  one-cycle pulse marking frame completion.
REQ-011 data_out  out  DATA_LENGTH  last received word; holds until the next completion.
REQ-012 SS  out  1  active-low slave select.
REQ-013 SCK  out  1  serial clock.
REQ-014 MOSI  out  1  serial data to the slave.
REQ-015 MISO  in  1  serial data from the slave; SHALL pass through a 2-flop synchronizer before use.

Function
REQ-016 The block SHALL implement FSM states IDLE, LEAD, XFER and TRAIL.
REQ-017 IDLE -> LEAD SHALL occur when start=1 and busy=0; on that cycle data_in is latched into the TX shift register and busy rises.
REQ-018 A start asserted while busy=1 SHALL be ignored (no queueing).
REQ-019 In LEAD, SS=0 for one half-period (CLK_DIV cycles) while SCK=CPOL.
REQ-020 For CPHA=0, MOSI SHALL present bit 0 from entry to LEAD.
REQ-021 In XFER, SCK SHALL toggle every CLK_DIV cycles, for exactly 2*DATA_LENGTH edges (DATA_LENGTH leading and DATA_LENGTH trailing).
REQ-022 Bit order SHALL be LSB first on both MOSI and MISO.
REQ-023 CPHA=0: MISO is sampled into the RX register on each leading edge; MOSI advances to the next bit on each trailing edge, except the final trailing edge.
REQ-024 CPHA=1: MOSI advances on each leading edge (bit 0 on the first); MISO is sampled on each trailing edge.
REQ-025 Sampling SHALL use the synchronized MISO value at the clk cycle of the sample edge.
REQ-026 XFER -> TRAIL after the final edge; SCK=CPOL and SS=0 are held for one half-period.
REQ-027 TRAIL -> IDLE: SS returns to 1, done=1 for one cycle, data_out is loaded from the RX register in the same cycle, and busy falls.
REQ-028 SS SHALL be low for exactly (2*DATA_LENGTH+2)*CLK_DIV clk cycles per frame.
REQ-029 start asserted in the same cycle as done SHALL be accepted, giving back-to-back frames with SS high for at least 1 cycle.
REQ-030 In IDLE, MOSI=0, SCK=CPOL and SS=1.
REQ-031 A half-period counter of width $clog2(CLK_DIV+1) SHALL count 0..CLK_DIV-1 and wrap.
REQ-032 A bit/edge counter SHALL count 0..2*DATA_LENGTH-1 and SHALL NOT wrap within a frame.

Reset
REQ-033 While rst_n=0, the following SHALL hold regardless of state (including mid-frame): SS=1, SCK=CPOL, MOSI=0, busy=0, done=0, data_out=0, FSM=IDLE, counters=0, shift registers=0.
REQ-034 Reset deassertion SHALL NOT produce any SCK edge or done pulse.

Structure
REQ-035 FSM state encoding and the mode enumeration (CPOL/CPHA pair) SHALL reside in shared package spi_pkg, for reuse by the slave side.
REQ-036 The SCK half-period generator SHALL be a sub-module spi_clk_gen, with inputs clk, rst_n, enable and outputs lead_edge, trail_edge, sck.
REQ-037 All other logic SHALL reside in spi_master.

Verification
REQ-038 Mode 0, CLK_DIV=2, data_in=8'hA5, SPI_slave model returning 8'h3C -> MOSI bits 1,0,1,0,0,1,0,1; data_out=8'h3C; SS low for 36 cycles; one done pulse.
REQ-039 Modes 1, 2 and 3 with the same data -> identical data_out; SCK idle level equals CPOL before and after the frame.
REQ-040 start asserted 5 cycles into a frame -> ignored; exactly one done pulse; busy remains continuously high.
REQ-041 start on the done cycle with data_in=8'h0F -> second frame starts immediately; SS high for >=1 cycle between frames; second data_out correct.
REQ-042 rst_n pulsed low mid-XFER -> SS=1, SCK=CPOL, busy=0, data_out=0 asynchronously; next start yields a correct full frame.
REQ-043 CLK_DIV=1, DATA_LENGTH=16, data_in=16'h8001 with MISO looped back to MOSI -> data_out=16'h8001; SS low for 34 cycles.
